usbh_utmi_port: RTL and testbench

Host/hub-side downstream port line-state controller for a UTMI transceiver, the peer of the function-side `usbf_utmi_ls` state machine. It tracks device connect/disconnect, drives bus reset, detects the device chirp K, and answers with the host K/J chirp sequence to negotiate HS or FS. It also handles suspend and resume, both host-initiated and device remote wakeup. It sits between the host port/hub status logic and the UTMI PHY, and drives the UTMI mode pins plus line-drive commands to the transmit path.

---
 rtl/usbh_utmi_port.sv | 143 ++++++++++++++
 tb/tb_usbh_utmi_port.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/usbh_utmi_port.sv
// usbh_utmi_port: host-side UTMI downstream port line-state controller (attach, reset/chirp, suspend/resume)
module usbh_utmi_port #(
    parameter int T_ATTACH    = 6_000_000,
    parameter int T_DISC      = 150,
    parameter int T_RESET     = 600_000,
    parameter int T_CHIRP_DET = 150,
    parameter int T_CHIRP     = 3_000,
    parameter int T_RESUME    = 1_200_000,
    parameter int T_EOP       = 10,
    parameter int CNT_W       = 23
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] LineState,
    input  logic       HostDisconnect,
    input  logic       port_reset_req,
    input  logic       port_suspend_req,
    input  logic       port_resume_req,
    output logic       XcvSelect,
    output logic       TermSel,
    output logic [1:0] OpMode,
    output logic       drive_se0,
    output logic       drive_k,
    output logic       drive_j,
    output logic       connect,
    output logic       port_enabled,
    output logic       port_hs,
    output logic       port_suspended,
    output logic       remote_wake,
    output logic       reset_done
);
    localparam logic [10:0] DISC       = 11'b000_0000_0001;
    localparam logic [10:0] CONN       = 11'b000_0000_0010;
    localparam logic [10:0] RESET_SE0  = 11'b000_0000_0100;
    localparam logic [10:0] CHIRP_WAIT = 11'b000_0000_1000;
    localparam logic [10:0] CHIRP_K    = 11'b000_0001_0000;
    localparam logic [10:0] CHIRP_J    = 11'b000_0010_0000;
    localparam logic [10:0] FS_IDLE    = 11'b000_0100_0000;
    localparam logic [10:0] HS_IDLE    = 11'b000_1000_0000;
    localparam logic [10:0] SUSPEND    = 11'b001_0000_0000;
    localparam logic [10:0] RESUME_K   = 11'b010_0000_0000;
    localparam logic [10:0] RESUME_EOP = 11'b100_0000_0000;
    localparam logic [10:0] RST_ST  = RESET_SE0 | CHIRP_WAIT | CHIRP_K | CHIRP_J;
    localparam logic [10:0] SUSP_ST = SUSPEND | RESUME_K | RESUME_EOP;
    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_J   = 2'b01;
    localparam logic [1:0] LS_K   = 2'b10;
    localparam logic [CNT_W-1:0] L_ATTACH = CNT_W'(T_ATTACH - 1);
    localparam logic [CNT_W-1:0] L_DISC   = CNT_W'(T_DISC - 1);
    localparam logic [CNT_W-1:0] L_RESET  = CNT_W'(T_RESET - 1);
    localparam logic [CNT_W-1:0] L_CDET   = CNT_W'(T_CHIRP_DET - 1);
    localparam logic [CNT_W-1:0] L_CHIRP  = CNT_W'(T_CHIRP - 1);
    localparam logic [CNT_W-1:0] L_RESUME = CNT_W'(T_RESUME - 1);
    localparam logic [CNT_W-1:0] L_EOP    = CNT_W'(T_EOP - 1);

    logic [10:0]      state, nxt;
    logic [1:0]       ls_r;
    logic [CNT_W-1:0] ptmr, rtmr;
    logic             k1;
    logic             ls_se0, ls_j, ls_k, q, se0_gone, rst_end, wake;

    assign ls_se0   = ls_r == LS_SE0;
    assign ls_j     = ls_r == LS_J;
    assign ls_k     = ls_r == LS_K;
    // ptmr doubles as a consecutive-sample qualifier in the states that watch the line
    assign q        = (state == DISC) ? ls_j :
                      |(state & (CONN | FS_IDLE | SUSPEND)) ? ls_se0 :
                      (state == RESET_SE0) ? ls_k : 1'b1;
    assign se0_gone = ls_se0 && ptmr >= L_DISC;
    assign rst_end  = rtmr >= L_RESET;
    assign wake     = k1 && ls_k;

    // next-state selection with disconnect > reset > suspend > resume priority
    always_comb begin
        nxt = state;
        case (state)
            DISC:       nxt = (ls_j && ptmr >= L_ATTACH) ? CONN : DISC;
            CONN:       nxt = se0_gone ? DISC : port_reset_req ? RESET_SE0 : CONN;
            RESET_SE0:  nxt = rst_end ? FS_IDLE : (ls_k && ptmr >= L_CDET) ? CHIRP_WAIT : RESET_SE0;
            CHIRP_WAIT: nxt = rst_end ? FS_IDLE : ls_se0 ? CHIRP_K : CHIRP_WAIT;
            CHIRP_K:    nxt = rst_end ? HS_IDLE : (ptmr >= L_CHIRP) ? CHIRP_J : CHIRP_K;
            CHIRP_J:    nxt = rst_end ? HS_IDLE : (ptmr >= L_CHIRP) ? CHIRP_K : CHIRP_J;
            FS_IDLE:    nxt = se0_gone ? DISC : port_reset_req ? RESET_SE0 :
                              port_suspend_req ? SUSPEND : FS_IDLE;
            HS_IDLE:    nxt = HostDisconnect ? DISC : port_reset_req ? RESET_SE0 :
                              port_suspend_req ? SUSPEND : HS_IDLE;
            SUSPEND:    nxt = se0_gone ? DISC : port_reset_req ? RESET_SE0 :
                              (wake || port_resume_req) ? RESUME_K : SUSPEND;
            RESUME_K:   nxt = (ptmr >= L_RESUME) ? RESUME_EOP : RESUME_K;
            RESUME_EOP: nxt = (ptmr >= L_EOP) ? (port_hs ? HS_IDLE : FS_IDLE) : RESUME_EOP;
            default:    nxt = DISC;
        endcase
    end

    // state, line sample and saturating timers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= DISC;
            ls_r  <= LS_SE0;
            ptmr  <= '0;
            rtmr  <= '0;
            k1    <= 1'b0;
        end else begin
            state <= nxt;
            ls_r  <= LineState;
            ptmr  <= (nxt != state || !q) ? '0 : ptmr + CNT_W'(!(&ptmr));
            rtmr  <= (nxt == RESET_SE0 && state != RESET_SE0) ? '0 : rtmr + CNT_W'(!(&rtmr));
            k1    <= state == SUSPEND && nxt == SUSPEND && ls_k;
        end
    end

    // outputs decoded from the next state so they move together with the state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            XcvSelect      <= 1'b1;
            TermSel        <= 1'b1;
            OpMode         <= 2'b01;
            drive_se0      <= 1'b0;
            drive_k        <= 1'b0;
            drive_j        <= 1'b0;
            connect        <= 1'b0;
            port_enabled   <= 1'b0;
            port_hs        <= 1'b0;
            port_suspended <= 1'b0;
            remote_wake    <= 1'b0;
            reset_done     <= 1'b0;
        end else begin
            XcvSelect      <= ~|(nxt & (RST_ST | HS_IDLE));
            TermSel        <= nxt != HS_IDLE;
            OpMode         <= |(nxt & (DISC | CONN)) ? 2'b01 :
                              |(nxt & (FS_IDLE | HS_IDLE | SUSPEND)) ? 2'b00 : 2'b10;
            drive_se0      <= |(nxt & (RESET_SE0 | RESUME_EOP));
            drive_k        <= |(nxt & (CHIRP_K | RESUME_K));
            drive_j        <= nxt == CHIRP_J;
            connect        <= nxt != DISC;
            port_enabled   <= |(nxt & (FS_IDLE | HS_IDLE | SUSP_ST));
            port_hs        <= (nxt == HS_IDLE) ? 1'b1 : |(nxt & (DISC | RESET_SE0)) ? 1'b0 : port_hs;
            port_suspended <= |(nxt & SUSP_ST);
            remote_wake    <= state == SUSPEND && nxt == RESUME_K && wake;
            reset_done     <= |(state & RST_ST) && |(nxt & (FS_IDLE | HS_IDLE));
        end
    end
endmodule

// File: tb/tb_usbh_utmi_port.sv
// tb_usbh_utmi_port: scoreboard bench; every output change is matched against a timed expected event
module tb_usbh_utmi_port;
    localparam logic [1:0] SE0 = 2'b00, J = 2'b01, K = 2'b10;
    // {XcvSelect, TermSel, OpMode, se0, k, j, connect, enabled, hs, suspended, remote_wake, reset_done}
    localparam logic [12:0] V_DISC = {2'b11, 2'b01, 3'b000, 4'b0000, 2'b00};
    localparam logic [12:0] V_CONN = {2'b11, 2'b01, 3'b000, 4'b1000, 2'b00};
    localparam logic [12:0] V_RST  = {2'b01, 2'b10, 3'b100, 4'b1000, 2'b00};
    localparam logic [12:0] V_WAIT = {2'b01, 2'b10, 3'b000, 4'b1000, 2'b00};
    localparam logic [12:0] V_CK   = {2'b01, 2'b10, 3'b010, 4'b1000, 2'b00};
    localparam logic [12:0] V_CJ   = {2'b01, 2'b10, 3'b001, 4'b1000, 2'b00};
    localparam logic [12:0] V_FS   = {2'b11, 2'b00, 3'b000, 4'b1100, 2'b00};
    localparam logic [12:0] V_FSD  = {2'b11, 2'b00, 3'b000, 4'b1100, 2'b01};
    localparam logic [12:0] V_HS   = {2'b00, 2'b00, 3'b000, 4'b1110, 2'b00};
    localparam logic [12:0] V_HSD  = {2'b00, 2'b00, 3'b000, 4'b1110, 2'b01};
    localparam logic [12:0] V_SUS  = {2'b11, 2'b00, 3'b000, 4'b1111, 2'b00};
    localparam logic [12:0] V_RK   = {2'b11, 2'b10, 3'b010, 4'b1111, 2'b00};
    localparam logic [12:0] V_RKW  = {2'b11, 2'b10, 3'b010, 4'b1111, 2'b10};
    localparam logic [12:0] V_EOP  = {2'b11, 2'b10, 3'b100, 4'b1111, 2'b00};

    logic clk = 1'b0;
    logic rst;
    logic [1:0] LineState;
    logic HostDisconnect, port_reset_req, port_suspend_req, port_resume_req;
    logic XcvSelect, TermSel, drive_se0, drive_k, drive_j;
    logic connect, port_enabled, port_hs, port_suspended, remote_wake, reset_done;
    logic [1:0] OpMode;
    logic [12:0] ob, prev;
    int cyc = 0;
    int nchk = 0;
    int npass = 0;
    int t;

    typedef struct { int c; logic [12:0] v; string name; } exp_t;
    exp_t sb[$];
    exp_t e;

    usbh_utmi_port #(
        .T_ATTACH(20), .T_DISC(4), .T_RESET(200), .T_CHIRP_DET(5),
        .T_CHIRP(10), .T_RESUME(30), .T_EOP(3), .CNT_W(23)
    ) dut (
        .clk(clk), .rst(rst), .LineState(LineState), .HostDisconnect(HostDisconnect),
        .port_reset_req(port_reset_req), .port_suspend_req(port_suspend_req),
        .port_resume_req(port_resume_req), .XcvSelect(XcvSelect), .TermSel(TermSel),
        .OpMode(OpMode), .drive_se0(drive_se0), .drive_k(drive_k), .drive_j(drive_j),
        .connect(connect), .port_enabled(port_enabled), .port_hs(port_hs),
        .port_suspended(port_suspended), .remote_wake(remote_wake), .reset_done(reset_done)
    );

    assign ob = {XcvSelect, TermSel, OpMode, drive_se0, drive_k, drive_j,
                 connect, port_enabled, port_hs, port_suspended, remote_wake, reset_done};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input string nm, input int c, input logic [12:0] v);
        sb.push_back('{c: c, v: v, name: nm});
    endtask

    task automatic chk(input string nm, input logic [12:0] got, input logic [12:0] req,
                       input int gc, input int rc);
        nchk++;
        if (got === req && gc == rc) npass++;
        else $display("FAIL %s: got %h at cycle %0d, required %h at cycle %0d", nm, got, gc, req, rc);
    endtask

    initial begin
        rst = 1'b1;
        LineState = SE0;
        HostDisconnect = 1'b0;
        port_reset_req = 1'b0;
        port_suspend_req = 1'b0;
        port_resume_req = 1'b0;
        fork
            forever begin
                @(negedge clk);
                if (!rst) prev = ob;
                else if (ob !== prev) begin
                    if (sb.size() == 0) chk("unexpected_change", ob, prev, cyc, cyc);
                    else begin
                        e = sb.pop_front();
                        chk(e.name, ob, e.v, cyc, e.c);
                    end
                    prev = ob;
                end
            end
        join_none
        #2 rst = 1'b0;
        step(3);
        rst = 1'b1;
        chk("reset_values", ob, V_DISC, cyc, cyc);
        // FS attach, short SE0 in CONN, dropped suspend request
        step(2);
        LineState = J; t = cyc;
        expect_at("attach", t + 21, V_CONN);
        step(30);
        port_suspend_req = 1'b1; step; port_suspend_req = 1'b0;
        LineState = SE0; step(3); LineState = J;
        step(10);
        // FS bus reset, no chirp
        port_reset_req = 1'b1; LineState = SE0; t = cyc;
        expect_at("fs_reset_se0", t + 1, V_RST);
        expect_at("fs_reset_done", t + 201, V_FSD);
        expect_at("fs_idle", t + 202, V_FS);
        step; port_reset_req = 1'b0;
        step(189); LineState = J;
        step(20);
        // short K glitch during reset
        port_reset_req = 1'b1; LineState = SE0; t = cyc;
        expect_at("glitch_reset_se0", t + 1, V_RST);
        expect_at("glitch_reset_done", t + 201, V_FSD);
        expect_at("glitch_fs_idle", t + 202, V_FS);
        step; port_reset_req = 1'b0;
        step(19); LineState = K; step(3); LineState = SE0;
        step(167); LineState = J;
        step(20);
        // HS handshake with a late reset request that must not restart the reset timer
        port_reset_req = 1'b1; LineState = SE0; t = cyc;
        expect_at("hs_reset_se0", t + 1, V_RST);
        expect_at("hs_chirp_wait", t + 16, V_WAIT);
        for (int i = 0; i < 10; i++) begin
            expect_at("hs_chirp_k", t + 20 + 20 * i, V_CK);
            if (i < 9) expect_at("hs_chirp_j", t + 30 + 20 * i, V_CJ);
        end
        expect_at("hs_reset_done", t + 201, V_HSD);
        expect_at("hs_idle", t + 202, V_HS);
        step; port_reset_req = 1'b0;
        step(9); LineState = K; step(8); LineState = SE0;
        step(82); port_reset_req = 1'b1; step; port_reset_req = 1'b0;
        step(117);
        // resume request outside SUSPEND is dropped
        port_resume_req = 1'b1; step; port_resume_req = 1'b0;
        step(3);
        // host suspend / resume
        LineState = J; port_suspend_req = 1'b1; t = cyc;
        expect_at("suspend", t + 1, V_SUS);
        step; port_suspend_req = 1'b0;
        step(10);
        port_resume_req = 1'b1; t = cyc;
        expect_at("resume_k", t + 1, V_RK);
        expect_at("resume_eop", t + 31, V_EOP);
        expect_at("resume_hs_idle", t + 34, V_HS);
        step; port_resume_req = 1'b0;
        step(40);
        // remote wake after a single-sample K that must be ignored
        port_suspend_req = 1'b1; t = cyc;
        expect_at("suspend2", t + 1, V_SUS);
        step; port_suspend_req = 1'b0;
        step(5);
        LineState = K; step; LineState = J;
        step(5);
        LineState = K; t = cyc;
        expect_at("remote_wake", t + 3, V_RKW);
        expect_at("wake_resume_k", t + 4, V_RK);
        expect_at("wake_eop", t + 33, V_EOP);
        expect_at("wake_hs_idle", t + 36, V_HS);
        step(5); LineState = J;
        step(40);
        // HS disconnect, then a reset request in DISC is dropped
        HostDisconnect = 1'b1; LineState = SE0; t = cyc;
        expect_at("hs_disconnect", t + 1, V_DISC);
        step; HostDisconnect = 1'b0;
        step(3);
        port_reset_req = 1'b1; step; port_reset_req = 1'b0;
        step(5);
        // asynchronous reset while driving chirp K
        LineState = J; t = cyc;
        expect_at("reattach", t + 21, V_CONN);
        step(25);
        port_reset_req = 1'b1; LineState = SE0; t = cyc;
        expect_at("mid_reset_se0", t + 1, V_RST);
        expect_at("mid_chirp_wait", t + 16, V_WAIT);
        expect_at("mid_chirp_k", t + 20, V_CK);
        step; port_reset_req = 1'b0;
        step(9); LineState = K; step(8); LineState = SE0;
        step(7);
        rst = 1'b0;
        #1;
        chk("async_reset", ob, V_DISC, cyc, cyc);
        step(3);
        rst = 1'b1;
        step(5);
        nchk++;
        if (sb.size() == 0) npass++;
        else $display("FAIL scoreboard_drain: %0d expected events never seen, required 0 (next %s at cycle %0d)",
                      sb.size(), sb[0].name, sb[0].c);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
